stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/modulo_stage.sv | 23 ++
 rtl/stopwatch_controller.sv | 112 +++++++++++
 tb/tb_stopwatch_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encodings and digit limits shared by the stopwatch blocks.
package stopwatch_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } state_t;
    localparam logic [7:0] CENTI_LIM = 8'd100;
    localparam logic [7:0] SEC_LIM   = 8'd60;
    localparam logic [7:0] MIN_LIM   = 8'd60;
endpackage

// File: rtl/modulo_stage.sv
// modulo_stage: one wrapping digit counter; carry is high on the enabled step that wraps to 0.
module modulo_stage (
    input  logic       qzt_clk,
    input  logic       reset_n,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic [7:0] i_limit,
    output logic [7:0] o_value,
    output logic       o_carry
);
    logic [7:0] r_value;
    assign o_carry = i_enable && (r_value == i_limit - 8'd1);
    assign o_value = r_value;
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_enable) begin
            r_value <= o_carry ? '0 : r_value + 8'd1;
        end
    end
endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: MM:SS.CC stopwatch with start/stop, lap hold and clear,
// a prescaled 10 ms tick and a registered two-digit display page.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500000
) (
    input  logic        qzt_clk,
    input  logic        reset_n,
    input  logic        btn_startstop,
    input  logic        btn_lapclear,
    input  logic        disp_sel,
    output logic [7:0]  centis,
    output logic [7:0]  seconds,
    output logic [7:0]  minutes,
    output logic [15:0] disp_out,
    output logic [1:0]  state,
    output logic        overflow
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    state_t        r_state, w_next;
    logic          r_ss_q, r_lc_q, r_overflow;
    logic [PW-1:0] r_presc;
    logic [23:0]   r_snap;
    logic [15:0]   r_disp;
    logic          w_ss_rise, w_lc_rise, w_lap_rise, w_counting, w_tick, w_clear;
    logic          w_c_carry, w_s_carry, w_m_carry;
    logic [23:0]   w_live, w_src;

    assign w_ss_rise  = btn_startstop & ~r_ss_q;
    assign w_lc_rise  = btn_lapclear & ~r_lc_q;
    // startstop wins a simultaneous press, so lapclear only acts alone
    assign w_lap_rise = w_lc_rise & ~w_ss_rise;
    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == PW'(TICK_DIV - 1));
    assign w_clear    = (r_state == S_IDLE) || ((r_state == S_STOP) && w_lap_rise);
    assign w_live     = {minutes, seconds, centis};
    assign w_src      = (r_state == S_LAP) ? r_snap : w_live;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_ss_rise ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_ss_rise ? S_STOP : w_lap_rise ? S_LAP : S_RUN;
            S_LAP:   w_next = w_ss_rise ? S_STOP : w_lap_rise ? S_RUN : S_LAP;
            S_STOP:  w_next = w_ss_rise ? S_RUN : w_lap_rise ? S_IDLE : S_STOP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ss_q     <= 1'b1;
            r_lc_q     <= 1'b1;
            r_presc    <= '0;
            r_overflow <= 1'b0;
            r_snap     <= '0;
            r_disp     <= '0;
        end else begin
            r_state <= w_next;
            r_ss_q  <= btn_startstop;
            r_lc_q  <= btn_lapclear;
            if (w_clear) begin
                r_presc <= '0;
            end else if (w_counting) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_clear) begin
                r_overflow <= 1'b0;
            end else if (w_m_carry) begin
                r_overflow <= 1'b1;
            end
            if ((r_state == S_RUN) && w_lap_rise) begin
                r_snap <= w_live;
            end
            r_disp <= disp_sel ? w_src[15:0] : w_src[23:8];
        end
    end

    modulo_stage u_centi (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .i_enable(w_tick),
        .i_clear (w_clear),
        .i_limit (CENTI_LIM),
        .o_value (centis),
        .o_carry (w_c_carry)
    );
    modulo_stage u_sec (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .i_enable(w_c_carry),
        .i_clear (w_clear),
        .i_limit (SEC_LIM),
        .o_value (seconds),
        .o_carry (w_s_carry)
    );
    modulo_stage u_min (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .i_enable(w_s_carry),
        .i_clear (w_clear),
        .i_limit (MIN_LIM),
        .o_value (minutes),
        .o_carry (w_m_carry)
    );

    assign disp_out = r_disp;
    assign state    = r_state;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: directed vectors, corner sequences and random stimulus
// against a reference that keeps elapsed time as a single centisecond total.
module tb_stopwatch_controller;
    localparam int TD = 4;
    localparam int FULL = 60 * 60 * 100;

    logic        clk = 1'b0;
    logic        reset_n, btn_startstop, btn_lapclear, disp_sel;
    logic [7:0]  centis, seconds, minutes;
    logic [15:0] disp_out;
    logic [1:0]  state;
    logic        overflow;

    int n_checks = 0;
    int n_fail = 0;
    int m_state, m_total, m_presc, m_snap, m_ovf, m_disp;
    bit m_ss_q, m_lc_q;

    typedef struct {
        bit ss;
        bit lc;
        bit sel;
        int exp_state;
    } vec_t;
    vec_t tbl[12];

    stopwatch_controller #(.TICK_DIV(TD)) dut (
        .qzt_clk      (clk),
        .reset_n      (reset_n),
        .btn_startstop(btn_startstop),
        .btn_lapclear (btn_lapclear),
        .disp_sel     (disp_sel),
        .centis       (centis),
        .seconds      (seconds),
        .minutes      (minutes),
        .disp_out     (disp_out),
        .state        (state),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int disp_word(int t, bit sel);
        int mi, se, ce;
        mi = t / 6000;
        se = (t / 100) % 60;
        ce = t % 100;
        return sel ? (se * 256 + ce) : (mi * 256 + se);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_total = 0;
        m_presc = 0;
        m_snap = 0;
        m_ovf = 0;
        m_disp = 0;
        m_ss_q = 1'b1;
        m_lc_q = 1'b1;
    endtask

    task automatic model_step();
        bit ssr, lcr, cnt, tk;
        int nxt;
        ssr = btn_startstop && !m_ss_q;
        lcr = btn_lapclear && !m_lc_q && !ssr;
        m_ss_q = btn_startstop;
        m_lc_q = btn_lapclear;
        m_disp = disp_word(m_state == 3 ? m_snap : m_total, disp_sel);
        if (m_state == 1 && lcr) m_snap = m_total;
        cnt = (m_state == 1) || (m_state == 3);
        tk = cnt && (m_presc == TD - 1);
        if (cnt) m_presc = tk ? 0 : m_presc + 1;
        if (tk) begin
            m_total = m_total + 1;
            if (m_total == FULL) begin
                m_total = 0;
                m_ovf = 1;
            end
        end
        nxt = m_state;
        if (ssr) nxt = cnt ? 2 : 1;
        else if (lcr) nxt = (m_state == 1) ? 3 : (m_state == 3) ? 1 : (m_state == 2) ? 0 : m_state;
        if (m_state == 0 || (m_state == 2 && nxt == 0)) begin
            m_total = 0;
            m_presc = 0;
            m_ovf = 0;
        end
        m_state = nxt;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".centis"}, int'(centis), m_total % 100);
        chk({tag, ".seconds"}, int'(seconds), (m_total / 100) % 60);
        chk({tag, ".minutes"}, int'(minutes), m_total / 6000);
        chk({tag, ".disp_out"}, int'(disp_out), m_disp);
        chk({tag, ".overflow"}, int'(overflow), m_ovf);
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic press(bit ss, bit lc, string tag);
        btn_startstop = ss;
        btn_lapclear = lc;
        cycle(tag);
        btn_startstop = 1'b0;
        btn_lapclear = 1'b0;
        cycle(tag);
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".state"}, int'(state), 0);
        chk({tag, ".centis"}, int'(centis), 0);
        chk({tag, ".seconds"}, int'(seconds), 0);
        chk({tag, ".minutes"}, int'(minutes), 0);
        chk({tag, ".disp_out"}, int'(disp_out), 0);
        chk({tag, ".overflow"}, int'(overflow), 0);
    endtask

    initial begin
        int c0;
        reset_n = 1'b0;
        btn_startstop = 1'b0;
        btn_lapclear = 1'b0;
        disp_sel = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        cycle("idle");
        btn_lapclear = 1'b1;
        cycle("idle_lc");
        btn_lapclear = 1'b0;
        cycle("idle_lc");
        chk("idle_ignores_lap", int'(state), 0);

        // first count: 99 cs after 396 cycles, 1.00 s after 400
        btn_startstop = 1'b1;
        cycle("start");
        btn_startstop = 1'b0;
        chk("start.state", int'(state), 1);
        repeat (396) cycle("run");
        chk("cnt396.centis", int'(centis), 99);
        chk("cnt396.seconds", int'(seconds), 0);
        repeat (4) cycle("run");
        chk("cnt400.centis", int'(centis), 0);
        chk("cnt400.seconds", int'(seconds), 1);

        // lap hold at 00:01.23
        repeat (92) cycle("run");
        chk("pre_lap.centis", int'(centis), 23);
        disp_sel = 1'b1;
        btn_lapclear = 1'b1;
        cycle("lap");
        btn_lapclear = 1'b0;
        chk("lap.state", int'(state), 3);
        cycle("lap");
        chk("lap.disp", int'(disp_out), 16'h0117);
        repeat (20) cycle("lap");
        chk("lap_hold.disp", int'(disp_out), 16'h0117);
        chk("lap_live.centis", int'(centis), 28);
        disp_sel = 1'b0;
        cycle("lap");
        chk("lap_sel0.disp", int'(disp_out), 16'h0001);
        disp_sel = 1'b1;
        btn_lapclear = 1'b1;
        cycle("unlap");
        btn_lapclear = 1'b0;
        chk("unlap.state", int'(state), 1);
        cycle("unlap");
        chk("unlap.disp", int'(disp_out), disp_word(m_total - ((m_presc == 0) ? 1 : 0), 1'b1));

        // freeze with prescaler at 2, resume, then clear from STOP
        for (int i = 0; i < 2 * TD && m_presc != 1; i++) cycle("align");
        btn_startstop = 1'b1;
        cycle("stop");
        btn_startstop = 1'b0;
        chk("stop.state", int'(state), 2);
        c0 = m_total;
        repeat (10) cycle("frozen");
        chk("frozen.centis", int'(centis), c0 % 100);
        chk("frozen.seconds", int'(seconds), (c0 / 100) % 60);
        btn_startstop = 1'b1;
        cycle("resume");
        btn_startstop = 1'b0;
        cycle("resume");
        chk("resume1.centis", int'(centis), c0 % 100);
        cycle("resume");
        chk("resume2.centis", int'(centis), (c0 + 1) % 100);
        press(1'b1, 1'b0, "stop2");
        btn_lapclear = 1'b1;
        cycle("clear");
        btn_lapclear = 1'b0;
        cycle("clear");
        check_zero("cleared");

        // wrap at 59:59.99 with sticky overflow
        press(1'b1, 1'b0, "ovf_run");
        press(1'b1, 1'b0, "ovf_stop");
        force dut.u_centi.r_value = 8'd99;
        force dut.u_sec.r_value = 8'd59;
        force dut.u_min.r_value = 8'd59;
        #1;
        release dut.u_centi.r_value;
        release dut.u_sec.r_value;
        release dut.u_min.r_value;
        m_total = FULL - 1;
        cycle("preload");
        btn_startstop = 1'b1;
        cycle("ovf_go");
        btn_startstop = 1'b0;
        for (int i = 0; i < 2 * TD && m_total == FULL - 1; i++) cycle("ovf_wait");
        chk("wrap.minutes", int'(minutes), 0);
        chk("wrap.seconds", int'(seconds), 0);
        chk("wrap.centis", int'(centis), 0);
        chk("wrap.overflow", int'(overflow), 1);
        press(1'b1, 1'b0, "ovf_stop2");
        chk("ovf_stop.overflow", int'(overflow), 1);
        press(1'b1, 1'b0, "ovf_run2");
        repeat (10) cycle("ovf_run2");
        chk("ovf_run.overflow", int'(overflow), 1);
        press(1'b1, 1'b0, "ovf_stop3");
        press(1'b0, 1'b1, "ovf_clear");
        chk("ovf_clear.overflow", int'(overflow), 0);
        chk("ovf_clear.state", int'(state), 0);

        // simultaneous press, then a held button across reset release
        press(1'b1, 1'b0, "both_run");
        repeat (5) cycle("both_run");
        press(1'b1, 1'b1, "both");
        chk("both.state", int'(state), 2);
        btn_startstop = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cycle("held");
        chk("held.state", int'(state), 0);
        btn_startstop = 1'b0;
        cycle("held");
        press(1'b1, 1'b0, "after_held");
        chk("after_held.state", int'(state), 1);

        // asynchronous reset mid-cycle while in LAP
        press(1'b0, 1'b1, "lap2");
        repeat (9) cycle("lap2");
        chk("lap2.state", int'(state), 3);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_zero("async_rst_hold");
        reset_n = 1'b1;
        cycle("post_rst");

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 3};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 0};
        foreach (tbl[i]) begin
            disp_sel = tbl[i].sel;
            press(tbl[i].ss, tbl[i].lc, "tbl");
            chk($sformatf("tbl[%0d].state", i), int'(state), tbl[i].exp_state);
        end

        for (int i = 0; i < 3000; i++) begin
            btn_startstop = ($urandom_range(9) == 0);
            btn_lapclear = ($urandom_range(7) == 0);
            if ($urandom_range(4) == 0) disp_sel = ~disp_sel;
            if ($urandom_range(499) == 0) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                check_zero("rnd_rst");
                @(negedge clk);
                reset_n = 1'b1;
            end
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
